// File: rtl/record_serializer.sv
// -----------------------------------------------------------------------------
// record_serializer
//   Accepts one 64-bit packed record {a[31:0], b[15:0], c[7:0], d[7:0]} and
//   streams it out one byte per accepted beat, optionally followed by an XOR
//   checksum byte. Byte order is selectable (MSB-first or LSB-first); the field
//   tag always reflects where the byte sits in the record, not its beat number.
//
// Parameters
//   CHECKSUM  : 1 = append XOR-of-all-bytes beat after the record, 0 = omit
//   MSB_FIRST : 1 = bits 63..0 downward, 0 = bits 0..63 upward
//
// Ports
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : record handshake (ready only while idle)
//   in_data[63:0]        : packed record
//   out_valid/out_ready  : byte handshake
//   out_data[7:0]        : current byte
//   out_field[2:0]       : 0=a 1=b 2=c 3=d 4=checksum
//   out_last             : final beat of the record
//   frame_count[15:0]    : completed records, wraps
// -----------------------------------------------------------------------------
module record_serializer #(
  parameter int CHECKSUM  = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [2:0]  out_field,
  output logic        out_last,
  output logic [15:0] frame_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] CSUM = 2'd2;

  logic [1:0]  state_q;
  logic [63:0] hold_q;
  logic [2:0]  idx_q;
  logic [7:0]  csum_q;
  logic [15:0] fc_q;

  logic [5:0]  idx_bits;
  logic [5:0]  bit_base;
  logic [7:0]  cur_byte;
  logic [2:0]  cur_field;
  logic        accept;
  logic        last_data_beat;

  // Low bit of the current byte inside the record. For MSB-first, index 0
  // lands on bit 56 and index 7 on bit 0, so the subtraction never underflows.
  assign idx_bits = {idx_q, 3'b000};
  assign bit_base = (MSB_FIRST != 0) ? (6'd56 - idx_bits) : idx_bits;
  assign cur_byte = hold_q[bit_base +: 8];

  // Field follows bit position: [63:32] a, [31:16] b, [15:8] c, [7:0] d.
  always_comb begin
    cur_field = 3'd3;
    if (bit_base[5])      cur_field = 3'd0;
    else if (bit_base[4]) cur_field = 3'd1;
    else if (bit_base[3]) cur_field = 3'd2;
  end

  assign last_data_beat = (idx_q == 3'd7);

  // Outputs are pure decodes of registered state, so they cannot move while
  // a beat is being held off by out_ready.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_field = 3'd0;
    out_last  = 1'b0;
    case (state_q)
      SEND: begin
        out_valid = 1'b1;
        out_data  = cur_byte;
        out_field = cur_field;
        out_last  = (CHECKSUM == 0) && last_data_beat;
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_field = 3'd4;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign accept      = out_valid && out_ready;
  assign frame_count = fc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      fc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hold_q  <= in_data;
            idx_q   <= '0;
            csum_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            csum_q <= csum_q ^ cur_byte;
            idx_q  <= idx_q + 3'd1;
            if (last_data_beat) begin
              if (CHECKSUM != 0) begin
                state_q <= CSUM;
              end else begin
                state_q <= IDLE;
                fc_q    <= fc_q + 16'd1;
              end
            end
          end
        end
        CSUM: begin
          if (accept) begin
            state_q <= IDLE;
            fc_q    <= fc_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
